// File: rtl/keccak_buffer_out.sv
// -----------------------------------------------------------------------------
// keccak_buffer_out
//
// Output-side buffer for the keccak core. The core pulses digest_valid for one
// cycle with the final digest; this block captures it and serializes it as
// NUM_WORDS words of OUT_WIDTH bits over a valid/ready stream. Word 0 is the
// least significant slice of the digest (bits [OUT_WIDTH-1:0]).
//
// Optional build macro: KECCAK_BUFFER_OUT_SKID_EN
//   When defined, a single pending-digest slot lets one more digest be held
//   while the active one is still streaming. When undefined, only the active
//   digest is stored.
//
// Handshake: a word transfers on every rising edge where dout_valid &&
// dout_ready. While dout_valid is high and dout_ready is low, dout, word_idx
// and dout_last are held. dout_valid never drops inside a digest.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   digest_in      in   DIGEST_WIDTH digest, sampled when digest_valid=1
//   digest_valid   in   single-cycle digest strobe from the core
//   accept_ready   out  combinational; a digest_valid this cycle is accepted
//   dout           out  current output word
//   dout_valid     out  dout holds a valid word
//   dout_ready     in   consumer accepts dout
//   dout_last      out  current word is the final word of the digest
//   word_idx       out  index of the current word
//   overflow       out  sticky: a digest was dropped
//   clear_overflow in   synchronous clear of overflow (a new drop wins)
//   state_o        out  debug view of the FSM state (0=IDLE, 1=SEND)
// -----------------------------------------------------------------------------
module keccak_buffer_out #(
    parameter int DIGEST_WIDTH = 256,
    parameter int OUT_WIDTH    = 32,
    localparam int NUM_WORDS   = DIGEST_WIDTH / OUT_WIDTH,
    localparam int IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIGEST_WIDTH-1:0] digest_in,
    input  logic                    digest_valid,
    output logic                    accept_ready,
    output logic [OUT_WIDTH-1:0]    dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic [IDX_W-1:0]        word_idx,
    output logic                    overflow,
    input  logic                    clear_overflow,
    output logic                    state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        word_idx_q;
    logic [IDX_W-1:0]        word_idx_d;
    logic [DIGEST_WIDTH-1:0] data_q;
    logic                    overflow_q;
    logic                    xfer;
    logic                    fin;
    logic                    is_last;

`ifdef KECCAK_BUFFER_OUT_SKID_EN
    logic [DIGEST_WIDTH-1:0] pend_q;
    logic                    pend_valid_q;
`endif

    assign is_last    = (word_idx_q == IDX_W'(NUM_WORDS - 1));
    assign dout_valid = (state_q == SEND);
    assign dout_last  = dout_valid && is_last;
    assign xfer       = dout_valid && dout_ready;
    assign fin        = xfer && is_last;
    assign word_idx_d = word_idx_q + IDX_W'(1);

    // The data register is cleared on reset, so dout reads 0 out of reset.
    assign dout     = data_q[word_idx_q*OUT_WIDTH +: OUT_WIDTH];
    assign word_idx = word_idx_q;
    assign overflow = overflow_q;
    assign state_o  = state_q;

`ifdef KECCAK_BUFFER_OUT_SKID_EN
    // Room exists while the pending slot is empty, or when it frees up this
    // cycle because the active digest finishes and the pending one moves up.
    assign accept_ready = !pend_valid_q || fin;
`else
    // No skid: accept only when idle or when the last word leaves this cycle.
    assign accept_ready = (state_q == IDLE) || fin;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            data_q       <= '0;
            overflow_q   <= 1'b0;
`ifdef KECCAK_BUFFER_OUT_SKID_EN
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
`endif
        end else begin
            // Drop detection; set has priority over clear.
            if (digest_valid && !accept_ready) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end

`ifdef KECCAK_BUFFER_OUT_SKID_EN
            if (state_q == IDLE) begin
                // The slot is always empty in IDLE: a finishing digest with a
                // pending one behind it stays in SEND.
                if (digest_valid) begin
                    data_q     <= digest_in;
                    word_idx_q <= '0;
                    state_q    <= SEND;
                end
            end else if (fin) begin
                word_idx_q <= '0;
                if (pend_valid_q) begin
                    data_q <= pend_q;
                    if (digest_valid) begin
                        pend_q <= digest_in;
                    end else begin
                        pend_valid_q <= 1'b0;
                    end
                end else if (digest_valid) begin
                    data_q <= digest_in;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                if (xfer) begin
                    word_idx_q <= word_idx_d;
                end
                if (digest_valid && !pend_valid_q) begin
                    pend_q       <= digest_in;
                    pend_valid_q <= 1'b1;
                end
            end
`else
            if (digest_valid && accept_ready) begin
                // Covers both IDLE and a load on the final-word transfer,
                // which restarts at word 0 without an idle cycle.
                data_q     <= digest_in;
                word_idx_q <= '0;
                state_q    <= SEND;
            end else if (fin) begin
                word_idx_q <= '0;
                state_q    <= IDLE;
            end else if (xfer) begin
                word_idx_q <= word_idx_d;
            end
`endif
        end
    end

endmodule
